// File: rtl/dot_result_serializer_pkg.sv
// dot_result_serializer_pkg: shared widths, byte count and serializer state encoding
package dot_result_serializer_pkg;
  localparam int SUM_W  = 19;
  localparam int ACC_W  = 24;
  localparam int BYTE_W = 8;
  localparam int NBYTES = ACC_W / BYTE_W;
  localparam int IDX_W  = $clog2(NBYTES);
  typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/dot_result_serializer.sv
// dot_result_serializer: accumulates adder-tree sums and streams snapshots LSB-first as bytes
module dot_result_serializer
  import dot_result_serializer_pkg::*;
#(
  parameter int SUM_W  = dot_result_serializer_pkg::SUM_W,
  parameter int ACC_W  = dot_result_serializer_pkg::ACC_W,
  parameter int BYTE_W = dot_result_serializer_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic              capture,
  input  logic              clear,
  input  logic              send,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);
  localparam int NB = ACC_W / BYTE_W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [ACC_W-1:0] acc_q, acc_d, sh_q, sh_d;
  logic [ACC_W:0]   add;
  logic             ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;
  state_e           state_q, state_d;
  logic             fire, last, start;

  always_comb begin
    add   = {1'b0, acc_q} + (ACC_W+1)'(sum_in);
    acc_d = clear ? (capture ? ACC_W'(sum_in) : '0) : (capture ? add[ACC_W-1:0] : acc_q);
    ovf_d = !clear && (ovf_q || (capture && add[ACC_W]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  // the snapshot takes acc_q, so a same-cycle capture or clear is not included
  always_comb begin
    last    = idx_q == IW'(NB - 1);
    fire    = (state_q == SEND) && out_ready;
    start   = (state_q == IDLE) && send;
    state_d = (state_q == IDLE) ? (send ? SEND : IDLE) : ((fire && last) ? IDLE : SEND);
    sh_d    = start ? acc_q : (fire ? sh_q >> BYTE_W : sh_q);
    idx_d   = start ? '0 : (fire ? idx_q + IW'(1) : idx_q);
  end

  always_comb begin
    out_valid = state_q == SEND;
    busy      = state_q == SEND;
    out_data  = sh_q[BYTE_W-1:0];
    out_last  = (state_q == SEND) && last;
    ovf       = ovf_q;
  end
endmodule

// File: tb/tb_dot_result_serializer.sv
// tb_dot_result_serializer: directed plus random stimulus against an arithmetic reference model
module tb_dot_result_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1, capture = 1'b0, clear = 1'b0, send = 1'b0, out_ready = 1'b0;
  logic [18:0] sum_in = '0;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, ovf;

  int          n_chk = 0, n_fail = 0;
  longint      acc_m = 0;
  bit          ovf_m = 0;
  logic [7:0]  q[$];
  string       ph = "init";

  dot_result_serializer dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .capture(capture), .clear(clear), .send(send),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s:%s observed %h expected %h", ph, tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, advance the model at the edge, check outputs on the falling edge
  task automatic step(bit r, bit cap, bit clr, bit snd, bit rdy, logic [18:0] s);
    bit was_idle;
    rst = r; capture = cap; clear = clr; send = snd; out_ready = rdy; sum_in = s;
    @(posedge clk);
    if (r) begin
      acc_m = 0; ovf_m = 0; q.delete();
    end else begin
      was_idle = q.size() == 0;
      if (!was_idle && rdy) void'(q.pop_front());
      if (was_idle && snd)
        for (int k = 0; k < 3; k++) q.push_back(8'((acc_m >> (8 * k)) & 255));
      if (clr) begin
        acc_m = cap ? longint'(s) : 0; ovf_m = 0;
      end else if (cap) begin
        acc_m = acc_m + longint'(s);
        if (acc_m >= 64'd16777216) begin ovf_m = 1; acc_m = acc_m - 64'd16777216; end
      end
    end
    @(negedge clk);
    chk("valid", out_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("ovf", ovf, ovf_m);
    if (q.size() != 0) begin
      chk("data", out_data, q[0]);
      chk("last", out_last, q.size() == 1);
    end else chk("last_idle", out_last, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) step(0, 0, 0, 0, 1, 0);
    chk("drained_busy", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    ph = "reset";
    step(1, 0, 0, 0, 0, 0);
    chk("out_data", out_data, 8'h00);
    step(0, 0, 0, 0, 0, 0);

    ph = "basic";
    step(0, 1, 0, 0, 0, 19'h01234);
    step(0, 0, 0, 1, 1, 0);
    chk("b0", out_data, 8'h34);
    step(0, 0, 0, 0, 1, 0);
    chk("b1", out_data, 8'h12);
    step(0, 0, 0, 0, 1, 0);
    chk("b2", out_data, 8'h00);
    chk("b2_last", out_last, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("busy_after", busy, 0);

    ph = "accum";
    step(0, 0, 1, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 19'h7FFFF);
    step(0, 0, 0, 1, 1, 0);
    chk("b0", out_data, 8'hFE);
    step(0, 0, 0, 0, 1, 0);
    chk("b1", out_data, 8'hFF);
    step(0, 0, 0, 0, 1, 0);
    chk("b2", out_data, 8'h0F);
    chk("ovf", ovf, 0);
    drain();

    ph = "ovf";
    step(0, 0, 1, 0, 0, 0);
    repeat (33) step(0, 1, 0, 0, 0, 19'h7FFFF);
    chk("ovf_set", ovf, 1);
    step(0, 0, 0, 1, 1, 0);
    chk("b0", out_data, 8'hDF);
    step(0, 0, 0, 0, 1, 0);
    chk("b1", out_data, 8'hFF);
    step(0, 0, 0, 0, 1, 0);
    chk("b2", out_data, 8'h07);
    drain();
    step(0, 0, 1, 0, 0, 0);
    chk("ovf_clr", ovf, 0);
    step(0, 1, 1, 0, 0, 19'h00005);
    step(0, 0, 0, 1, 1, 0);
    chk("clrcap_b0", out_data, 8'h05);
    drain();

    ph = "bp";
    step(0, 0, 1, 0, 0, 0);
    repeat (21) step(0, 1, 0, 0, 0, 19'h7FFFF);
    step(0, 1, 0, 0, 0, 19'h3CE04);
    step(0, 0, 0, 1, 0, 0);
    repeat (3) begin
      step(0, 0, 0, 0, 0, 0);
      chk("hold_data", out_data, 8'hEF);
      chk("hold_last", out_last, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("b1", out_data, 8'hCD);
    step(0, 0, 0, 0, 1, 0);
    chk("b2", out_data, 8'hAB);
    chk("b2_last", out_last, 1);
    drain();

    ph = "cap_send";
    step(0, 1, 1, 0, 0, 19'h00010);
    step(0, 0, 0, 1, 1, 0);
    chk("b0", out_data, 8'h10);
    step(0, 1, 0, 1, 1, 19'h00020);
    step(0, 0, 0, 1, 1, 0);
    chk("b2", out_data, 8'h00);
    step(0, 0, 0, 1, 1, 0);
    chk("ignored_busy", busy, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("s2_b0", out_data, 8'h30);
    drain();

    ph = "rst_mid";
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("valid_rst", out_valid, 0);
    chk("busy_rst", busy, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("b0", out_data, 8'h00);
    drain();

    ph = "rand";
    repeat (80)
      step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), 19'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_result_serializer.md
Name: dot_result_serializer

Overview:
Downstream stage of the 8-lane MAC/adder-tree dot-product array. Takes the 19-bit combinational adder-tree sum and accumulates it across passes into a wider accumulator, so dot products longer than 8 lanes can be tiled. On command it snapshots the accumulator and streams it out LSB-first as bytes over a valid/ready handshake to the 8-bit output pins. Accumulation may continue while a previous snapshot is still streaming.

Parameters:
SUM_W, 19, width of the adder-tree sum input
ACC_W, 24, accumulator width; must be >= SUM_W and a multiple of 8
BYTE_W, 8, width of the output byte

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
sum_in  in  SUM_W  adder-tree sum, unsigned, sampled on capture
capture  in  1  pulse: acc <= acc + zero-extended sum_in
clear  in  1  pulse: zero acc and ovf
send  in  1  pulse: snapshot acc and start a byte stream
out_data  out  BYTE_W  current byte of the stream
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts the byte when out_valid is also high
out_last  out  1  high with the final byte of the stream
busy  out  1  a stream is in progress (state SEND)
ovf  out  1  sticky accumulator carry-out flag

Behaviour:
- Reset (synchronous, active-high): acc=0, ovf=0, state=IDLE, byte index=0, shift reg=0, out_valid=0, out_last=0, busy=0, out_data=0. Reset mid-stream aborts the stream. No partial bytes appear after reset.
- Accumulator path (independent of state):
  - clear only: acc<=0, ovf<=0.
  - capture only: acc<=acc+sum_in, wrapping modulo 2^ACC_W. A carry-out sets ovf.
  - clear and capture together: acc<=sum_in, ovf<=0.
  - Neither: hold.
- State machine, NBYTES = ACC_W/8 (3 at defaults):
  - IDLE, send=1: shift reg <= pre-update acc value, excluding any same-cycle capture or clear. Index<=0, go to SEND. out_valid rises the next cycle (1-cycle latency).
  - SEND: out_valid=1, busy=1, out_data=shift reg[7:0], out_last=(index==NBYTES-1).
    - On out_valid&&out_ready: shift right by 8, index++.
    - If that byte was the last one, go to IDLE; out_valid, out_last and busy drop the next cycle.
  - No bubble between bytes when out_ready is held high: NBYTES consecutive transfer cycles.
- Backpressure: while out_valid && !out_ready, out_data, out_last and index are held stable.
- send while in SEND is ignored; the current stream is unaffected and no error is flagged.
- send is not accepted in the cycle the last byte transfers; it must arrive while IDLE.
- capture and clear during SEND modify acc only, never the in-flight snapshot.
- send does not clear acc; software issues clear explicitly.

Decomposition:
- Shared package:
  - state enum {IDLE, SEND}
  - localparam NBYTES = ACC_W/BYTE_W
  - index width = $clog2(NBYTES)
  - Same constants used by the top-level to wire sum_in to the adder-tree output.
- No sub-module. The accumulator and the serializer FSM stay in one module, with the accumulator kept in its own always block.

Test Plan:
- Basic stream: reset; sum_in=0x01234, capture; send; out_ready=1 -> bytes 0x34, 0x12, 0x00 on three consecutive cycles, out_last only on the third, busy low the cycle after.
- Accumulate: capture 0x7FFFF twice, send -> stream 0xFE, 0xFF, 0x0F (acc=0x0FFFFE), ovf=0.
- Overflow: capture 0x7FFFF 33 times -> acc=0x07FFDF, ovf=1. clear -> acc=0, ovf=0. clear+capture(0x00005) same cycle -> acc=0x000005.
- Backpressure: acc=0xABCDEF, send, out_ready low for 3 cycles after out_valid rises -> out_data holds 0xEF. Then ready high -> 0xEF, 0xCD, 0xAB, out_last with 0xAB.
- Capture during SEND: acc=0x000010, send, capture 0x00020 while streaming -> stream 0x10, 0x00, 0x00. Second send -> 0x30, 0x00, 0x00. A send issued mid-stream is ignored.
- Reset mid-stream: rst high after the first byte transfers -> next cycle out_valid=0, busy=0, acc=0. A subsequent send streams 0x00, 0x00, 0x00.
